uart_rx_fifo: RTL and testbench

//   Parametrised UART receiver with a receive FIFO; successor to the single-buffer serial receiver.

---
 rtl/uart_rx_fifo.sv | 171 +++++++++++++++++
 tb/tb_uart_rx_fifo.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_fifo.sv
// UART receiver: 2-flop synchroniser, mid-bit sampling FSM, optional parity check,
// and a show-ahead receive FIFO with framing/parity/overrun flags.
`timescale 1ns/1ps
module uart_rx_fifo #(
  parameter int DATA_BITS    = 8,
  parameter int CLKS_PER_BIT = 10,
  parameter int PARITY_EN    = 0,
  parameter int PARITY_ODD   = 0,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                              clk,
  input  logic                              n_rst,
  input  logic                              serial_in,
  input  logic                              data_read,
  output logic [DATA_BITS-1:0]              rx_data,
  output logic                              data_ready,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]   fifo_count,
  output logic                              overrun_error,
  output logic                              framing_error,
  output logic                              parity_error
);

  localparam int CNT_W  = $clog2(CLKS_PER_BIT);
  localparam int IDX_W  = $clog2(DATA_BITS);
  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int FCNT_W = $clog2(FIFO_DEPTH+1);

  localparam logic [CNT_W-1:0]  HALF_M1  = CNT_W'(CLKS_PER_BIT/2 - 1);
  localparam logic [CNT_W-1:0]  FULL_M1  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(DATA_BITS - 1);
  localparam logic [FCNT_W-1:0] DEPTH_C  = FCNT_W'(FIFO_DEPTH);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_START  = 3'd1;
  localparam logic [2:0] S_DATA   = 3'd2;
  localparam logic [2:0] S_PARITY = 3'd3;
  localparam logic [2:0] S_STOP   = 3'd4;
  localparam logic [2:0] S_CHECK  = 3'd5;

  function automatic logic parity_bad(input logic [DATA_BITS-1:0] d, input logic p);
    return ((^d) ^ p) != (PARITY_ODD != 0);
  endfunction

  logic                 sync1, sync2, sync3;
  logic [2:0]           state;
  logic [CNT_W-1:0]     cnt;
  logic [IDX_W-1:0]     bit_idx;
  logic [DATA_BITS-1:0] shreg;
  logic                 par_bad;
  logic                 stop_bit;
  logic                 start_det;
  logic                 good, push, pop, full;
  logic [PTR_W-1:0]     wr_ptr, rd_ptr;
  logic [DATA_BITS-1:0] mem [FIFO_DEPTH];

  // sync3 holds the previous synchronised level for falling-edge detection
  always_ff @(posedge clk) begin
    if (!n_rst) begin
      sync1 <= 1'b1;
      sync2 <= 1'b1;
      sync3 <= 1'b1;
    end else begin
      sync1 <= serial_in;
      sync2 <= sync1;
      sync3 <= sync2;
    end
  end

  assign start_det = (state == S_IDLE) && sync3 && !sync2;

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      state         <= S_IDLE;
      cnt           <= '0;
      bit_idx       <= '0;
      par_bad       <= 1'b0;
      stop_bit      <= 1'b1;
      framing_error <= 1'b0;
      parity_error  <= 1'b0;
    end else begin
      cnt <= (cnt == FULL_M1) ? '0 : cnt + 1'b1;
      case (state)
        S_IDLE: begin
          if (start_det) begin
            state         <= S_START;
            cnt           <= '0;
            framing_error <= 1'b0;
            parity_error  <= 1'b0;
          end
        end
        S_START: begin
          if (cnt == HALF_M1) begin
            cnt     <= '0;
            bit_idx <= '0;
            par_bad <= 1'b0;
            state   <= sync2 ? S_IDLE : S_DATA;
          end
        end
        S_DATA: begin
          if (cnt == FULL_M1) begin
            bit_idx <= bit_idx + 1'b1;
            if (bit_idx == LAST_IDX)
              state <= (PARITY_EN != 0) ? S_PARITY : S_STOP;
          end
        end
        S_PARITY: begin
          if (cnt == FULL_M1) begin
            par_bad <= parity_bad(shreg, sync2);
            state   <= S_STOP;
          end
        end
        S_STOP: begin
          if (cnt == FULL_M1) begin
            stop_bit <= sync2;
            state    <= S_CHECK;
          end
        end
        S_CHECK: begin
          state <= S_IDLE;
          if (!stop_bit)
            framing_error <= 1'b1;
          else if (par_bad)
            parity_error <= 1'b1;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Data bits arrive LSB first, so shift in at the top
  always_ff @(posedge clk) begin
    if (state == S_DATA && cnt == FULL_M1)
      shreg <= {sync2, shreg[DATA_BITS-1:1]};
  end

  assign good       = (state == S_CHECK) && stop_bit && !par_bad;
  assign data_ready = (fifo_count != '0);
  assign full       = (fifo_count == DEPTH_C);
  assign pop        = data_read && data_ready;
  assign push       = good && (!full || pop);
  assign rx_data    = data_ready ? mem[rd_ptr] : '1;

  always_ff @(posedge clk) begin
    if (push)
      mem[wr_ptr] <= shreg;
  end

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      fifo_count    <= '0;
      overrun_error <= 1'b0;
    end else begin
      if (push)
        wr_ptr <= wr_ptr + 1'b1;
      if (pop)
        rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + 1'b1;
        2'b01:   fifo_count <= fifo_count - 1'b1;
        default: fifo_count <= fifo_count;
      endcase
      if (pop)
        overrun_error <= 1'b0;
      else if (good && full)
        overrun_error <= 1'b1;
    end
  end

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Bench for uart_rx_fifo: directed scenarios plus random frames checked against a queue model.
`timescale 1ns/1ps
module tb_uart_rx_fifo;

  logic       clk = 1'b0;
  logic       n_rst = 1'b0;
  logic       serial_a = 1'b1, serial_b = 1'b1;
  logic       read_a = 1'b0, read_b = 1'b0;
  logic [7:0] rx_a, rx_b;
  logic       ready_a, ready_b;
  logic [2:0] cnt_a, cnt_b;
  logic       ovr_a, fe_a, pe_a, ovr_b, fe_b, pe_b;

  always #5 clk = ~clk;

  uart_rx_fifo #(.DATA_BITS(8), .CLKS_PER_BIT(10), .PARITY_EN(0), .PARITY_ODD(0), .FIFO_DEPTH(4)) u_a (
    .clk(clk), .n_rst(n_rst), .serial_in(serial_a), .data_read(read_a),
    .rx_data(rx_a), .data_ready(ready_a), .fifo_count(cnt_a),
    .overrun_error(ovr_a), .framing_error(fe_a), .parity_error(pe_a));

  uart_rx_fifo #(.DATA_BITS(8), .CLKS_PER_BIT(10), .PARITY_EN(1), .PARITY_ODD(0), .FIFO_DEPTH(4)) u_b (
    .clk(clk), .n_rst(n_rst), .serial_in(serial_b), .data_read(read_b),
    .rx_data(rx_b), .data_ready(ready_b), .fifo_count(cnt_b),
    .overrun_error(ovr_b), .framing_error(fe_b), .parity_error(pe_b));

  int tests_run = 0;
  int tests_failed = 0;

  // Reference model for u_a: stored frames, sticky flags
  logic [7:0] q[$];
  logic       m_fe = 1'b0;
  logic       m_ovr = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input bit sel, input logic v);
    if (sel) serial_b = v;
    else     serial_a = v;
  endtask

  task automatic send_start(input bit sel, input int period);
    drive(sel, 1'b0);
    #(period);
  endtask

  task automatic send_rest(input bit sel, input logic [7:0] d, input bit has_par,
                           input logic par, input logic stop, input int period);
    for (int i = 0; i < 8; i++) begin
      drive(sel, d[i]);
      #(period);
    end
    if (has_par) begin
      drive(sel, par);
      #(period);
    end
    drive(sel, stop);
    #(period);
    drive(sel, 1'b1);
    #300;
  endtask

  task automatic model_frame(input logic [7:0] d, input logic stop);
    if (!stop)             m_fe = 1'b1;
    else if (q.size() < 4) q.push_back(d);
    else                   m_ovr = 1'b1;
  endtask

  task automatic send_a(input logic [7:0] d, input logic stop, input int period);
    m_fe = 1'b0;
    send_start(1'b0, period);
    send_rest(1'b0, d, 1'b0, 1'b0, stop, period);
    model_frame(d, stop);
  endtask

  task automatic check_a(input string tag);
    logic [7:0] exp_rx;
    exp_rx = (q.size() != 0) ? q[0] : 8'hFF;
    @(negedge clk);
    check({tag, ".rx"},    rx_a,    exp_rx);
    check({tag, ".rdy"},   ready_a, q.size() != 0);
    check({tag, ".cnt"},   cnt_a,   q.size());
    check({tag, ".fe"},    fe_a,    m_fe);
    check({tag, ".pe"},    pe_a,    1'b0);
    check({tag, ".ovr"},   ovr_a,   m_ovr);
  endtask

  task automatic pop_a(input string tag);
    @(posedge clk);
    #1 read_a = 1'b1;
    @(posedge clk);
    #1 read_a = 1'b0;
    if (q.size() != 0) begin
      void'(q.pop_front());
      m_ovr = 1'b0;
    end
    check_a(tag);
  endtask

  task automatic do_reset();
    n_rst = 1'b0;
    repeat (2) @(posedge clk);
    #1 n_rst = 1'b1;
    q.delete();
    m_fe = 1'b0;
    m_ovr = 1'b0;
  endtask

  initial begin
    logic [7:0] d;
    logic       stop;
    int         period;
    int         npops;

    // Reset
    do_reset();
    check_a("reset");
    check("reset_b.rx",  rx_b,    8'hFF);
    check("reset_b.rdy", ready_b, 1'b0);

    // Good frame at nominal, fast and slow bit periods
    send_a(8'hF0, 1'b1, 100); check_a("f0_100"); pop_a("f0_100_pop");
    send_a(8'hF0, 1'b1, 96);  check_a("f0_96");  pop_a("f0_96_pop");
    send_a(8'hF0, 1'b1, 104); check_a("f0_104"); pop_a("f0_104_pop");

    // Framing error, then cleared at the next start detect
    send_a(8'hD3, 1'b0, 100); check_a("d3_frame");
    send_start(1'b0, 100);
    @(negedge clk);
    check("fe_clear_at_start", fe_a, 1'b0);
    m_fe = 1'b0;
    send_rest(1'b0, 8'hD2, 1'b0, 1'b0, 1'b1, 100);
    model_frame(8'hD2, 1'b1);
    check_a("d2_good");
    pop_a("d2_pop");

    // Overrun with a full FIFO
    for (int i = 1; i <= 5; i++) send_a(8'(i), 1'b1, 100);
    check_a("overrun");
    for (int i = 0; i < 4; i++) pop_a($sformatf("drain%0d", i));

    // Even parity instance
    send_start(1'b1, 100);
    send_rest(1'b1, 8'h03, 1'b1, 1'b1, 1'b1, 100);
    @(negedge clk);
    check("par_bad.pe",  pe_b,    1'b1);
    check("par_bad.fe",  fe_b,    1'b0);
    check("par_bad.rdy", ready_b, 1'b0);
    check("par_bad.rx",  rx_b,    8'hFF);
    send_start(1'b1, 100);
    send_rest(1'b1, 8'h03, 1'b1, 1'b0, 1'b1, 100);
    @(negedge clk);
    check("par_ok.pe",  pe_b,  1'b0);
    check("par_ok.rx",  rx_b,  8'h03);
    check("par_ok.cnt", cnt_b, 3'd1);
    send_start(1'b1, 100);
    send_rest(1'b1, 8'h07, 1'b1, 1'b1, 1'b1, 100);
    @(negedge clk);
    check("par_ok2.pe",  pe_b,  1'b0);
    check("par_ok2.cnt", cnt_b, 3'd2);
    check("par_ok2.rx",  rx_b,  8'h03);

    // Start glitch leaves FIFO and flags alone
    send_a(8'h5A, 1'b1, 100);
    check_a("pre_glitch");
    drive(1'b0, 1'b0);
    repeat (3) @(posedge clk);
    drive(1'b0, 1'b1);
    #300;
    check_a("glitch");

    // Reset in the middle of a frame
    send_start(1'b0, 100);
    drive(1'b0, 1'b1); #100;
    drive(1'b0, 1'b0); #100;
    drive(1'b0, 1'b1);
    do_reset();
    check_a("mid_reset");
    check("mid_reset_b.cnt", cnt_b, 3'd0);
    send_a(8'h3C, 1'b1, 100);
    check_a("after_reset");
    pop_a("after_reset_pop");

    // Random frames and reads
    for (int n = 0; n < 14; n++) begin
      d = 8'($urandom);
      stop = ($urandom_range(0, 5) != 0);
      case ($urandom_range(0, 2))
        0:       period = 96;
        1:       period = 104;
        default: period = 100;
      endcase
      if (!stop) period = 100;
      send_a(d, stop, period);
      check_a($sformatf("rnd%0d", n));
      npops = $urandom_range(0, 2);
      for (int k = 0; k < npops; k++) pop_a($sformatf("rnd%0d_pop%0d", n, k));
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
